// File: rtl/uart_pkg.sv
// uart_pkg: constants, receiver state type and baud divisor helper used by
// uart_rx and uart_baud_gen.
//   OVERSAMPLE : ticks per serial bit
//   SAMPLE_MID : centre tick of a bit; the ticks on either side of it are
//                also sampled for the majority vote
//   rx_state_t : receiver FSM states
//   calc_div   : clocks per oversampling tick, rounded to nearest
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_MID = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  // round(clk_freq / (baud_rate * OVERSAMPLE)). A result below 1 means the
  // clock is too slow for the requested rate.
  function automatic int calc_div(input int clk_freq, input int baud_rate);
    longint den;
    den = longint'(baud_rate) * longint'(OVERSAMPLE);
    if (den <= 0) return 0;
    return int'((longint'(clk_freq) + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversampling tick generator.
//   sys_clk   : system clock, rising edge
//   sys_rst_n : asynchronous active-low reset
//   en        : counter runs while high, holds at 0 while low
//   restart   : synchronous restart, counter back to 0 (wins over en)
//   tick      : one-cycle strobe every DIV clocks while enabled
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 1) begin : g_div_check
    $error("uart_baud_gen: CLK_FREQ too low for BAUD_RATE (DIV < 1)");
  end

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart || !en) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, 8N1 by default, 8E1 when the
// macro UART_RX_PARITY_EN is defined.
//   sys_clk           : system clock, rising edge
//   sys_rst_n         : asynchronous active-low reset
//   uart_rxd_i        : serial line, idle high, asynchronous
//   uart_rx_valid_o   : one-cycle strobe, byte received
//   uart_rxdata_o     : received byte, updated only with the valid strobe
//   uart_frame_err_o  : one-cycle strobe, stop bit sampled low
//   uart_parity_err_o : one-cycle strobe, even parity mismatch (0 in 8N1)
//   dbg_state         : current FSM state
//
// Handshake: the three strobes are mutually exclusive, at most one per
// frame, and there is no backpressure; the consumer must take
// uart_rxdata_o in the cycle uart_rx_valid_o is high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd_i,
  output logic       uart_rx_valid_o,
  output logic [7:0] uart_rxdata_o,
  output logic       uart_frame_err_o,
  output logic       uart_parity_err_o,
  output rx_state_t  dbg_state
);

  localparam logic [4:0] T_FIRST = 5'(SAMPLE_MID - 1);
  localparam logic [4:0] T_MID   = 5'(SAMPLE_MID);
  localparam logic [4:0] T_LAST  = 5'(SAMPLE_MID + 1);
  localparam logic [4:0] T_END   = 5'(OVERSAMPLE);

  // Synchronizer plus one history flop for falling-edge detection. All
  // reset to 1 so reset release on an idle line never looks like a start.
  logic rxd_meta, rxd_sync, rxd_prev;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd_i;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  rx_state_t  state;
  logic       start_det, baud_en, tick;
  logic [3:0] tick_cnt;   // ticks already seen in the current bit
  logic [4:0] tick_num;   // 1-based number of the tick being taken now
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [1:0] early;      // samples from the first two vote ticks
  logic       vote, at_sample, at_end;
  logic       valid, frame_err;
  logic [7:0] rxdata;

`ifdef UART_RX_PARITY_EN
  logic parity_bad, parity_err;
`endif

  assign start_det = (state == IDLE) && rxd_prev && !rxd_sync;
  assign baud_en   = (state != IDLE);

  uart_baud_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) u_baud_gen (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .en       (baud_en),
    .restart  (start_det),
    .tick     (tick)
  );

  // Ticks are numbered 1..16 from the start edge, so the vote window
  // 7/8/9 straddles the bit centre and the decision lands on tick 9.
  assign tick_num  = {1'b0, tick_cnt} + 5'd1;
  assign at_sample = tick && (tick_num == T_LAST);
  assign at_end    = tick && (tick_num == T_END);
  assign vote      = (early[0] & early[1]) | (early[0] & rxd_sync) |
                     (early[1] & rxd_sync);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      early     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      rxdata    <= '0;
`ifdef UART_RX_PARITY_EN
      parity_bad <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif

      if (state != IDLE && state != BREAK && tick) begin
        tick_cnt <= at_end ? 4'd0 : tick_cnt + 4'd1;
        if (tick_num == T_FIRST) early[0] <= rxd_sync;
        if (tick_num == T_MID)   early[1] <= rxd_sync;
      end

      case (state)
        IDLE: begin
          if (start_det) begin
            state    <= START;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end
        end

        START: begin
          if (at_sample && vote) state <= IDLE;  // false start
          else if (at_end)       state <= DATA;
        end

        DATA: begin
          if (at_sample) shift <= {vote, shift[7:1]};
          if (at_end) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          // Even parity: data bits plus parity bit must XOR to 0.
          if (at_sample) parity_bad <= vote ^ (^shift);
          if (at_end)    state <= STOP;
        end
`endif

        // Leave as soon as the stop bit is decided so the next start edge
        // is caught with about half a bit of margin.
        STOP: begin
          if (at_sample) begin
            if (vote) begin
`ifdef UART_RX_PARITY_EN
              if (parity_bad) begin
                parity_err <= 1'b1;
              end else begin
                valid  <= 1'b1;
                rxdata <= shift;
              end
`else
              valid  <= 1'b1;
              rxdata <= shift;
`endif
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end

        // A held-low line yields one frame error; wait for it to go high.
        BREAK: begin
          if (rxd_sync) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign uart_rx_valid_o  = valid;
  assign uart_rxdata_o    = rxdata;
  assign uart_frame_err_o = frame_err;
  assign dbg_state        = state;

`ifdef UART_RX_PARITY_EN
  assign uart_parity_err_o = parity_err;
`else
  assign uart_parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. Frames are built bit by bit
// from the byte, the parity rule and the stop bit; the outcome each frame
// must produce is queued when the frame is sent and a monitor pops and
// compares whenever a strobe appears. Honours UART_RX_PARITY_EN.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_FREQ  = 50_000_000;
  localparam int BAUD_RATE = 115200;
  localparam int BIT_CLK   = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  // Valid strobe window after the start edge: 9.4 .. 9.6 bit-times.
  localparam int T_LO      = (94 * (CLK_FREQ / 100)) / (BAUD_RATE / 10);
  localparam int T_HI      = (96 * (CLK_FREQ / 100)) / (BAUD_RATE / 10);

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam logic [1:0] K_VALID  = 2'd1;
  localparam logic [1:0] K_FRAME  = 2'd2;
  localparam logic [1:0] K_PARITY = 2'd3;

  // ---------------- clock / reset ----------------
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       uart_rxd_i = 1'b1;
  logic       uart_rx_valid_o, uart_frame_err_o, uart_parity_err_o;
  logic [7:0] uart_rxdata_o;
  rx_state_t  dbg_state;

  always #10 sys_clk = ~sys_clk;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .sys_clk          (sys_clk),
    .sys_rst_n        (sys_rst_n),
    .uart_rxd_i       (uart_rxd_i),
    .uart_rx_valid_o  (uart_rx_valid_o),
    .uart_rxdata_o    (uart_rxdata_o),
    .uart_frame_err_o (uart_frame_err_o),
    .uart_parity_err_o(uart_parity_err_o),
    .dbg_state        (dbg_state)
  );

  int cyc = 0;
  always @(posedge sys_clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [9:0] exp_q[$];      // {kind, data}
  int         errors = 0;
  int         checks = 0;
  logic [7:0] last_data = 8'h00;
  bit         timed = 1'b0;
  int         t_start = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge sys_clk);
  endtask

  // ---------------- driver ----------------
  // rst_bit >= 0 pulses reset in the middle of that data bit and the frame
  // is then expected to produce nothing.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic par_flip, input int rst_bit);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (PAR_EN) bits.push_back((^b) ^ par_flip);
    bits.push_back(stop_bit);

    if (rst_bit < 0) begin
      if (!stop_bit)                 exp_q.push_back({K_FRAME, 8'h00});
      else if (PAR_EN && par_flip)   exp_q.push_back({K_PARITY, 8'h00});
      else                           exp_q.push_back({K_VALID, b});
    end

    t_start = cyc;
    for (int i = 0; i < bits.size(); i++) begin
      uart_rxd_i = bits[i];
      if (rst_bit >= 0 && i == rst_bit + 1) begin
        wait_clk(BIT_CLK / 2);
        sys_rst_n = 1'b0;
        wait_clk(3);
        sys_rst_n = 1'b1;
        wait_clk(BIT_CLK - BIT_CLK / 2 - 3);
      end else begin
        wait_clk(BIT_CLK);
      end
    end
  endtask

  task automatic idle_bits(input int n);
    uart_rxd_i = 1'b1;
    wait_clk(n * BIT_CLK);
  endtask

  // ---------------- monitor ----------------
  always @(negedge sys_clk) begin
    logic [9:0] e;
    logic [1:0] kind;
    if (!sys_rst_n) begin
      last_data = 8'h00;
    end else begin
      if (uart_rx_valid_o || uart_frame_err_o || uart_parity_err_o) begin
        check("strobe_exclusive",
              32'(uart_rx_valid_o) + 32'(uart_frame_err_o) + 32'(uart_parity_err_o), 1);
        kind = uart_rx_valid_o ? K_VALID : (uart_frame_err_o ? K_FRAME : K_PARITY);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe_kind", 32'(kind), 0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", 32'(kind), 32'(e[9:8]));
          if (e[9:8] == K_VALID) begin
            last_data = e[7:0];
            if (timed) begin
              timed = 1'b0;
              checks++;
              if (cyc - t_start < T_LO || cyc - t_start > T_HI) begin
                errors++;
                $display("FAIL valid_latency: got %0d clocks required %0d..%0d",
                         cyc - t_start, T_LO, T_HI);
              end
            end
          end
        end
      end
      checks++;
      if (uart_rxdata_o !== last_data) begin
        errors++;
        $display("FAIL rxdata: got %h expected %h", uart_rxdata_o, last_data);
        last_data = uart_rxdata_o;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    wait_clk(98000);
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [7:0] b2b[7];
  int         left_idle;

  initial begin
    b2b = '{8'h36, 8'h66, 8'h6C, 8'h61, 8'h73, 8'h68, 8'h36};

    wait_clk(5);
    @(negedge sys_clk);
    check("rst_valid", 32'(uart_rx_valid_o), 0);
    check("rst_frame", 32'(uart_frame_err_o), 0);
    check("rst_parity", 32'(uart_parity_err_o), 0);
    check("rst_data", 32'(uart_rxdata_o), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    sys_rst_n = 1'b1;
    idle_bits(1);

    // Single byte with latency window.
    timed = 1'b1;
    send_frame(8'h36, 1'b1, 1'b0, -1);
    idle_bits(1);
    check("latency_strobe_seen", 32'(timed), 0);
    timed = 1'b0;

    // Back-to-back frames, no idle gap.
    foreach (b2b[i]) send_frame(b2b[i], 1'b1, 1'b0, -1);
    idle_bits(1);

    // 1 us glitch: FSM must react and be back in IDLE within one bit.
    uart_rxd_i = 1'b0;
    wait_clk(50);
    uart_rxd_i = 1'b1;
    left_idle = 0;
    for (int n = 0; n < BIT_CLK - 50; n++) begin
      @(negedge sys_clk);
      if (dbg_state != IDLE) left_idle = 1;
    end
    check("glitch_detected", 32'(left_idle), 1);
    check("glitch_back_idle", 32'(dbg_state), 32'(IDLE));

    // Bad stop bit, line held low, then a good byte.
    send_frame(8'hA5, 1'b0, 1'b0, -1);
    wait_clk(2 * BIT_CLK);
    idle_bits(1);
    send_frame(8'h01, 1'b1, 1'b0, -1);
    idle_bits(1);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h55, 1'b1, 1'b0, -1);
    idle_bits(1);
    send_frame(8'h55, 1'b1, 1'b1, -1);
    idle_bits(1);
`endif

    // Reset mid-frame at data bit 4, then a clean byte.
    send_frame(8'hFF, 1'b1, 1'b0, 4);
    idle_bits(1);
    send_frame(8'h12, 1'b1, 1'b0, -1);
    idle_bits(1);

    // Randomized frames.
    for (int k = 0; k < 2; k++) begin
      logic [7:0] rb;
      logic       rstop, rflip;
      rb    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 3) != 0);
      rflip = 1'($urandom_range(0, 1));
      send_frame(rb, rstop, rflip, -1);
      if (!rstop || $urandom_range(0, 1) == 1) idle_bits(1);
    end

    idle_bits(2);
    check("all_expected_seen", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000, giving the sys_clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115200, giving the serial bit rate in bit/s.
REQ-003 The block SHALL have input sys_clk, width 1, as the system clock; all logic is on its rising edge.
REQ-004 The block SHALL have input sys_rst_n, width 1, as the reset: asynchronous, active-low.
REQ-005 The block SHALL have input uart_rxd_i, width 1, as the asynchronous serial line (idle high).
REQ-006 The block SHALL have output uart_rx_valid_o, width 1, as a one-cycle strobe marking that a byte was received.
REQ-007 The block SHALL have output uart_rxdata_o, width 8, as the received byte, valid when uart_rx_valid_o is high.
REQ-008 The block SHALL have output uart_frame_err_o, width 1, as a one-cycle strobe marking a bad stop bit.
REQ-009 The block SHALL have output uart_parity_err_o, width 1, as a one-cycle strobe marking a parity mismatch.

Function
REQ-010 uart_rxd_i SHALL pass through a 2-flop synchronizer before any use.
REQ-011 The oversampling tick SHALL fire once every DIV = round(CLK_FREQ/(BAUD_RATE*16)) clocks.
- DIV is computed at elaboration; DIV < 1 is an elaboration error.
- The tick counter runs only outside IDLE and restarts at 0 on start detection.
REQ-012 The state machine SHALL have the states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-013 IDLE SHALL move to START on a synchronized high-to-low transition of the line.
REQ-014 Each bit SHALL span 16 ticks, and its value SHALL be the majority vote of ticks 7, 8 and 9.
REQ-015 In START, a sampled 1 SHALL be a false start: return to IDLE with no strobe.
- A sampled 0 moves to DATA.
REQ-016 DATA SHALL receive 8 bits LSB first into a shift register.
- A 3-bit counter counts the bits; after bit 7 the FSM goes to PARITY if the parity feature is enabled, otherwise to STOP.
REQ-017 STOP SHALL act on the sampled stop bit at tick 9.
- Sampled 1: uart_rx_valid_o pulses the next cycle with uart_rxdata_o updated in the same cycle, then IDLE.
- Sampled 0: uart_frame_err_o pulses, uart_rx_valid_o stays low, uart_rxdata_o is unchanged, then BREAK.
REQ-018 BREAK SHALL wait until the synchronized line is high, then return to IDLE, so a held-low line produces exactly one frame error.
REQ-019 uart_rxdata_o SHALL hold its value between valid strobes.
REQ-020 The strobes SHALL be single-cycle, SHALL never be asserted together in one cycle, and SHALL occur at most once per frame.
REQ-021 There SHALL be no ready/backpressure input.
- The consumer must accept the byte in the strobe cycle; the next strobe is at least 10 bit-times later.
REQ-022 A falling edge during STOP after tick 9 SHALL be ignored; start detection resumes only in IDLE, so there is up to 0.5 bit of resync slack.

Reset
REQ-023 On reset, all outputs SHALL be 0, the FSM SHALL be in IDLE, all counters 0, and the synchronizer flops 1 (no false start on release).
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no strobe and no partial data on uart_rxdata_o.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined SHALL make the frame 8E1.
- The PARITY state samples one even-parity bit after the data bits.
- On a mismatch, uart_parity_err_o pulses instead of uart_rx_valid_o when the stop bit is good.
- If the stop bit is bad, only uart_frame_err_o pulses.
REQ-026 Macro UART_RX_PARITY_EN undefined SHALL make the frame 8N1 with the PARITY state absent, and uart_parity_err_o SHALL be tied to 0.

Structure
REQ-027 Shared package uart_pkg SHALL hold OVERSAMPLE=16, SAMPLE_MID=8, the FSM state typedef and the DIV computation function.
REQ-028 Sub-module uart_baud_gen SHALL produce the tick strobe from CLK_FREQ/BAUD_RATE with a synchronous enable/restart input; the FSM, shift register and flags stay in uart_rx.

Verification
REQ-029 Byte 0x36 sent 8N1 at 115200 with a 50 MHz clock SHALL give one valid strobe with data 0x36, 9.5±0.1 bit-times after the start edge, and no error strobe.
REQ-030 Back-to-back frames 36 66 6C 61 73 68 36 with no idle gap SHALL give 7 valid strobes with data in order.
REQ-031 A 1 µs low glitch on an idle line SHALL give no strobe, with the FSM back in IDLE within 1 bit-time.
REQ-032 Byte 0xA5 with the stop bit forced 0 and the line held low 3 bit-times SHALL give exactly one frame-error strobe and no valid strobe; a following good 0x01 SHALL be received.
REQ-033 With UART_RX_PARITY_EN, 0x55 with correct parity 0 SHALL give a valid strobe; 0x55 with parity 1 SHALL give a parity-error strobe and leave data unchanged.
REQ-034 Reset pulsed at data bit 4 of 0xFF, then 0x12 sent, SHALL give no strobe for 0xFF, one valid strobe with 0x12, and uart_rxdata_o = 0x00 until then.
